// File: rtl/yapay_zeka_vektor_birimi.sv
// yapay_zeka_vektor_birimi: signed dot product over loaded X/W element buffers
// Loads fill the buffers. RUN sums one product per cycle over min(sayi_x, sayi_w) elements.
module yapay_zeka_vektor_birimi #(
   parameter int DERINLIK = 16,
   parameter int VERI_BIT = 32,
   parameter bit DOYGUN   = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ddb_durdur_i,
   input  logic [2:0]  kontrol_i,
   input  logic        basla_i,
   input  logic        rs2_en_i,
   input  logic [31:0] deger1_i,
   input  logic [31:0] deger2_i,
   output logic        bitti_o,
   output logic [31:0] sonuc_o
);
   localparam logic [2:0] YZH_LD_W = 3'd0, YZH_CLR_W = 3'd1, YZH_LD_X = 3'd2, YZH_CLR_X = 3'd3, YZH_RUN = 3'd4;
   localparam int AB = $clog2(DERINLIK);
   localparam int CW = AB + 1;
   localparam int AW = 2 * VERI_BIT + AB;
   localparam int SW = (AW > 33) ? AW : 33;
   localparam logic signed [SW-1:0] UST = SW'(33'sh07FFFFFFF);
   localparam logic signed [SW-1:0] ALT = ~UST;
   localparam logic [CW-1:0] DOLU = CW'(DERINLIK);

   typedef enum logic [1:0] {BOSTA, HESAPLA, BITTI} durum_t;
   durum_t durum_q, durum_d;

   logic signed [VERI_BIT-1:0] x_q [DERINLIK];
   logic signed [VERI_BIT-1:0] w_q [DERINLIK];
   logic [CW-1:0] sayi_x, sayi_w, sayi_x_n, sayi_w_n, idx, n;
   logic signed [AW-1:0] acc, acc_n;
   logic signed [2*VERI_BIT-1:0] carpim;
   logic signed [SW-1:0] acc_g;
   logic [31:0] sonuc_n;
   logic kabul, son, x_y1, x_y2, w_y1, w_y2;

   // Second element is only written if it still fits, so counts saturate at DOLU
   assign kabul    = basla_i && !ddb_durdur_i && durum_q == BOSTA;
   assign n        = (sayi_x < sayi_w) ? sayi_x : sayi_w;
   assign son      = idx == n - CW'(1);
   assign x_y1     = sayi_x < DOLU;
   assign x_y2     = rs2_en_i && sayi_x < DOLU - CW'(1);
   assign w_y1     = sayi_w < DOLU;
   assign w_y2     = rs2_en_i && sayi_w < DOLU - CW'(1);
   assign sayi_x_n = sayi_x + CW'(x_y1) + CW'(x_y2);
   assign sayi_w_n = sayi_w + CW'(w_y1) + CW'(w_y2);
   assign carpim   = x_q[idx[AB-1:0]] * w_q[idx[AB-1:0]];
   assign acc_n    = acc + AW'(carpim);
   assign acc_g    = SW'(acc_n);
   assign sonuc_n  = !DOYGUN ? acc_g[31:0] : (acc_g > UST) ? 32'h7FFFFFFF : (acc_g < ALT) ? 32'h80000000 : acc_g[31:0];

   always_ff @(posedge clk_i)
      if (kabul && kontrol_i == YZH_LD_X) begin
         if (x_y1) x_q[sayi_x[AB-1:0]] <= deger1_i[VERI_BIT-1:0];
         if (x_y2) x_q[sayi_x[AB-1:0] + AB'(1)] <= deger2_i[VERI_BIT-1:0];
      end

   always_ff @(posedge clk_i)
      if (kabul && kontrol_i == YZH_LD_W) begin
         if (w_y1) w_q[sayi_w[AB-1:0]] <= deger1_i[VERI_BIT-1:0];
         if (w_y2) w_q[sayi_w[AB-1:0] + AB'(1)] <= deger2_i[VERI_BIT-1:0];
      end

   always_ff @(posedge clk_i)
      if (rst_i) durum_q <= BOSTA;
      else if (!ddb_durdur_i) durum_q <= durum_d;

   always_comb begin
      durum_d = durum_q;
      bitti_o = kontrol_i != YZH_RUN || durum_q == BITTI;
      if (durum_q == BOSTA && basla_i && kontrol_i == YZH_RUN) durum_d = (n == '0) ? BITTI : HESAPLA;
      else if (durum_q == HESAPLA && son) durum_d = BITTI;
      else if (durum_q == BITTI) durum_d = BOSTA;
   end

   always_ff @(posedge clk_i)
      if (rst_i) begin
         sayi_x  <= '0;
         sayi_w  <= '0;
         acc     <= '0;
         idx     <= '0;
         sonuc_o <= '0;
      end else if (!ddb_durdur_i) begin
         if (kabul) begin
            sayi_x <= (kontrol_i == YZH_LD_X) ? sayi_x_n : (kontrol_i == YZH_CLR_X) ? '0 : sayi_x;
            sayi_w <= (kontrol_i == YZH_LD_W) ? sayi_w_n : (kontrol_i == YZH_CLR_W) ? '0 : sayi_w;
            if (kontrol_i == YZH_RUN) begin
               acc <= '0;
               idx <= '0;
               if (n == '0) sonuc_o <= '0;
            end
         end
         if (durum_q == HESAPLA) begin
            acc <= acc_n;
            idx <= idx + CW'(1);
            if (son) sonuc_o <= sonuc_n;
         end
      end
endmodule

// File: tb/tb_yapay_zeka_vektor_birimi.sv
// tb_yapay_zeka_vektor_birimi: wrap and saturating units driven in parallel against a queue model
module tb_yapay_zeka_vektor_birimi;
   localparam int D = 16;
   localparam logic [2:0] LD_W = 3'd0, CLR_W = 3'd1, LD_X = 3'd2, CLR_X = 3'd3, RUN = 3'd4;
   localparam logic signed [127:0] SMAX = 128'sh7FFFFFFF;
   localparam logic signed [127:0] SMIN = -SMAX - 1;

   logic clk = 0, rst = 1, ddb = 0, basla = 0, rs2 = 0;
   logic [2:0] kontrol = RUN;
   logic [31:0] d1 = 0, d2 = 0;
   logic bitti0, bitti1;
   logic [31:0] sonuc0, sonuc1, last_e0;
   int n_chk = 0, n_fail = 0;
   logic signed [31:0] mx [$];
   logic signed [31:0] mw [$];

   always #5 clk = ~clk;

   yapay_zeka_vektor_birimi #(.DERINLIK(D), .VERI_BIT(32), .DOYGUN(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .ddb_durdur_i(ddb), .kontrol_i(kontrol), .basla_i(basla),
      .rs2_en_i(rs2), .deger1_i(d1), .deger2_i(d2), .bitti_o(bitti0), .sonuc_o(sonuc0));
   yapay_zeka_vektor_birimi #(.DERINLIK(D), .VERI_BIT(32), .DOYGUN(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .ddb_durdur_i(ddb), .kontrol_i(kontrol), .basla_i(basla),
      .rs2_en_i(rs2), .deger1_i(d1), .deger2_i(d2), .bitti_o(bitti1), .sonuc_o(sonuc1));

   task automatic model_load(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b, input logic r);
      if (k == LD_X) begin
         if (mx.size() < D) mx.push_back(a);
         if (r && mx.size() < D) mx.push_back(b);
      end
      if (k == LD_W) begin
         if (mw.size() < D) mw.push_back(a);
         if (r && mw.size() < D) mw.push_back(b);
      end
      if (k == CLR_X) mx.delete();
      if (k == CLR_W) mw.delete();
   endtask

   task automatic op(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b, input logic r);
      @(negedge clk);
      kontrol = k; d1 = a; d2 = b; rs2 = r; basla = 1; ddb = 0;
      #1;
      n_chk++;
      if (bitti0 !== 1'b1) begin n_fail++; $display("FAIL bitti_nonrun: got %b required 1", bitti0); end
      @(posedge clk);
      #1 basla = 0;
      model_load(k, a, b, r);
   endtask

   function automatic int model_n();
      return (mx.size() < mw.size()) ? mx.size() : mw.size();
   endfunction

   task automatic run_op(input string nm, input int st_at, input int st_len);
      logic signed [127:0] s;
      logic [31:0] e0, e1;
      int n, exp_c, got;
      n = model_n();
      s = 0;
      for (int i = 0; i < n; i++) s = s + 128'(mx[i]) * 128'(mw[i]);
      e0 = s[31:0];
      e1 = (s > SMAX) ? 32'h7FFFFFFF : (s < SMIN) ? 32'h80000000 : s[31:0];
      exp_c = (n == 0) ? 1 : n + 1 + st_len;
      got = -1;
      @(negedge clk);
      kontrol = RUN; basla = 1; rs2 = 0;
      for (int c = 0; c < 100; c++) begin
         ddb = (c >= st_at && c < st_at + st_len);
         #1;
         if (bitti0) begin got = c; break; end
         @(negedge clk);
      end
      n_chk++;
      if (got != exp_c) begin n_fail++; $display("FAIL %s cycle: got %0d required %0d", nm, got, exp_c); end
      n_chk++;
      if (sonuc0 !== e0) begin n_fail++; $display("FAIL %s wrap: got %h required %h", nm, sonuc0, e0); end
      n_chk++;
      if (sonuc1 !== e1) begin n_fail++; $display("FAIL %s sat: got %h required %h", nm, sonuc1, e1); end
      last_e0 = e0;
      if (got >= 0) begin @(posedge clk); #1; end
      basla = 0; ddb = 0;
   endtask

   task automatic clear_all();
      op(CLR_X, 0, 0, 0);
      op(CLR_W, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1; kontrol = RUN;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (sonuc0 !== 32'd0 || sonuc1 !== 32'd0) begin n_fail++; $display("FAIL reset_sonuc: got %h/%h required 0", sonuc0, sonuc1); end
      n_chk++;
      if (bitti0 !== 1'b0) begin n_fail++; $display("FAIL reset_bitti_run: got %b required 0", bitti0); end
      kontrol = LD_X;
      #1;
      n_chk++;
      if (bitti0 !== 1'b1) begin n_fail++; $display("FAIL reset_bitti_ld: got %b required 1", bitti0); end
      kontrol = RUN; rst = 0;
      run_op("reset_empty", 0, 0);
   endtask

   task automatic test_basic();
      clear_all();
      op(LD_X, 1, 2, 1);
      op(LD_X, 3, 4, 1);
      op(LD_W, 1, 1, 1);
      op(LD_W, 1, 1, 1);
      run_op("basic", 0, 0);
   endtask

   task automatic test_signs();
      clear_all();
      op(LD_X, -3, 5, 1);
      op(LD_X, 7, 0, 0);
      op(LD_W, 4, -2, 1);
      run_op("signs", 0, 0);
   endtask

   task automatic test_overflow();
      clear_all();
      for (int i = 0; i < 8; i++) begin
         op(LD_X, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
         op(LD_W, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
      end
      run_op("overflow_pos", 0, 0);
      op(CLR_X, 0, 0, 0);
      for (int i = 0; i < 8; i++) op(LD_X, 32'h80000000, 32'h80000000, 1);
      run_op("overflow_neg", 0, 0);
   endtask

   task automatic test_full();
      clear_all();
      for (int i = 0; i < 9; i++) op(LD_X, $urandom, $urandom, 1);
      op(LD_W, $urandom, 0, 0);
      for (int i = 0; i < 8; i++) op(LD_W, $urandom, $urandom, 1);
      op(LD_W, $urandom, 0, 0);
      run_op("full", 5, 2);
   endtask

   task automatic test_stall();
      clear_all();
      for (int i = 0; i < 4; i++) op(LD_X, $urandom_range(0, 1000) - 500, 0, 0);
      for (int i = 0; i < 3; i++) op(LD_W, $urandom_range(0, 1000) - 500, 0, 0);
      @(negedge clk);
      kontrol = LD_W; d1 = 32'h12345; rs2 = 1; basla = 1; ddb = 1;
      @(posedge clk);
      #1 basla = 0; ddb = 0;
      op(LD_W, 77, 0, 0);
      run_op("stall", 2, 3);
      op(CLR_W, 0, 0, 0);
      run_op("empty_w", 0, 0);
   endtask

   task automatic test_back_to_back();
      clear_all();
      for (int i = 0; i < 3; i++) op(LD_X, $urandom, $urandom, 1);
      for (int i = 0; i < 2; i++) op(LD_W, $urandom, $urandom, 1);
      run_op("b2b_first", 0, 0);
      run_op("b2b_second", 1, 1);
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (sonuc0 !== last_e0) begin n_fail++; $display("FAIL hold: got %h required %h", sonuc0, last_e0); end
   endtask

   task automatic test_reset_mid_run();
      clear_all();
      for (int i = 0; i < 2; i++) begin
         op(LD_X, $urandom_range(1, 100), $urandom_range(1, 100), 1);
         op(LD_W, $urandom_range(1, 100), $urandom_range(1, 100), 1);
      end
      @(negedge clk);
      kontrol = RUN; basla = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++;
         if (bitti0 !== 1'b0) begin n_fail++; $display("FAIL abort_bitti_pre c%0d: got %b required 0", c, bitti0); end
         if (c == 2) rst = 1;
         @(negedge clk);
      end
      rst = 0; basla = 0;
      mx.delete(); mw.delete();
      #1;
      n_chk++;
      if (sonuc0 !== 32'd0) begin n_fail++; $display("FAIL abort_sonuc: got %h required 0", sonuc0); end
      for (int c = 0; c < 6; c++) begin
         n_chk++;
         if (bitti0 !== 1'b0) begin n_fail++; $display("FAIL abort_bitti_post c%0d: got %b required 0", c, bitti0); end
         @(negedge clk);
         #1;
      end
      run_op("after_abort", 0, 0);
   endtask

   task automatic test_random();
      int n, sa, sl;
      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(0, 1)) op(CLR_X, 0, 0, 0);
         if ($urandom_range(0, 1)) op(CLR_W, 0, 0, 0);
         for (int j = $urandom_range(0, 10); j > 0; j--)
            op($urandom_range(0, 1) ? LD_X : LD_W, $urandom, $urandom, 1'($urandom_range(0, 1)));
         n = model_n();
         sa = 0; sl = 0;
         if (n > 0) begin
            sa = $urandom_range(1, n);
            sl = $urandom_range(0, n - sa + 1);
         end
         run_op($sformatf("random%0d", it), sa, sl);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_overflow();
      test_full();
      test_stall();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
